jtopl_wr_sched: RTL and testbench

//  CPU-side write scheduler for the OPL operator/channel register file. Latches the
//  OPL address/data port pair, queues data writes, decodes each register address

---
 rtl/jtopl_wr_sched.sv | 260 ++++++++++++++++++++++++++
 tb/tb_jtopl_wr_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_wr_sched.sv
// jtopl_wr_sched
//  CPU-side write scheduler for the OPL operator/channel register file.
//  Latches the OPL address/data port pair and queues data writes. Each queued
//  write is decoded into a group/subslot select and a single update strobe.
//  The strobe is held for HOLD_CEN cen ticks, which is one full 18-slot round
//  plus the pipeline drain, so the rotating slot counter is certain to meet it.
//  Registers 0x01 (wave_mode) and 0xBD (rhythm, depths) are owned here. Writes
//  to them bypass the queue and update on the next clk.
//
//  Optional feature: define JTOPL_WRQ_FIFO_EN to get a DEPTH-entry circular
//  FIFO. Without it the queue is a single holding register (capacity 1).
//
//  Parameters: HOLD_CEN (>=2) cen ticks a strobe is held.
//              DEPTH (FIFO build only, power of two, >=2) queue entries.
//  Ports:
//   clk, rst              clock, synchronous active-high reset
//   cen                   clock enable, one register-file slot per cen
//   cpu_wr/cpu_a0/cpu_din CPU strobe, port select (0 addr, 1 data), data
//   busy                  queue full; data writes while busy are dropped
//   write                 one-clk pulse when a decoded write is launched
//   din                   register-file data, stable from write until done
//   sel_group/sel_sub     target group / subslot
//   up_*                  one-hot operator/channel update strobes
//   wave_mode             reg 0x01 bit 5
//   am_dep/vib_dep/rhy_en/rhy_kon  reg 0xBD bits 7/6/5/4:0
module jtopl_wr_sched #(
  parameter int HOLD_CEN = 21
`ifdef JTOPL_WRQ_FIFO_EN
  ,
  parameter int DEPTH    = 4
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cpu_wr,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_din,
  output logic       busy,
  output logic       write,
  output logic [7:0] din,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_wav,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_fbcon,
  output logic       wave_mode,
  output logic       rhy_en,
  output logic [4:0] rhy_kon,
  output logic       am_dep,
  output logic       vib_dep
);

  localparam int CW = $clog2(HOLD_CEN + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD, DONE} state_t;

  state_t        state;
  logic [7:0]    addr_q;
  logic [CW-1:0] hold_cnt;
  logic [7:0]    ups;
  logic          is_global;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          q_empty;
  logic [15:0]   head;
  logic [7:0]    head_addr;
  logic [7:0]    head_data;
  logic          dec_valid;
  logic [1:0]    dec_group;
  logic [2:0]    dec_sub;
  logic [7:0]    dec_up;

  assign is_global = (addr_q == 8'h01) || (addr_q == 8'hBD);
  assign push_req  = cpu_wr && cpu_a0 && !is_global;
  // A full queue still accepts a push in the clk its head is popped.
  assign push_ok   = push_req && (!busy || pop);
  assign pop       = (state == IDLE) && !q_empty;
  assign head_addr = head[15:8];
  assign head_data = head[7:0];

  // Address latch and the two global registers; never blocked by the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= 8'h00;
      wave_mode <= 1'b0;
      am_dep    <= 1'b0;
      vib_dep   <= 1'b0;
      rhy_en    <= 1'b0;
      rhy_kon   <= 5'd0;
    end else if (cpu_wr) begin
      if (!cpu_a0)
        addr_q <= cpu_din;
      else if (addr_q == 8'h01)
        wave_mode <= cpu_din[5];
      else if (addr_q == 8'hBD)
        {am_dep, vib_dep, rhy_en, rhy_kon} <= cpu_din;
    end
  end

`ifdef JTOPL_WRQ_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign busy    = (count == (AW+1)'(DEPTH));
  assign q_empty = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage has no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {addr_q, cpu_din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (pop && !push_ok)
        count <= count - 1'b1;
    end
  end
`else
  logic        q_valid;
  logic [15:0] q_data;

  assign busy    = q_valid;
  assign q_empty = !q_valid;
  assign head    = q_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= 16'h0000;
    end else if (push_ok) begin
      q_data  <= {addr_q, cpu_din};
      q_valid <= 1'b1;
    end else if (pop) begin
      q_valid <= 1'b0;
    end
  end
`endif

  // Address decode of the queue head. Operator blocks use offsets 0x00-0x15
  // with subslots 6/7 unpopulated; channel blocks use channels 0-8.
  always_comb begin
    dec_valid = 1'b0;
    dec_group = 2'd0;
    dec_sub   = 3'd0;
    dec_up    = 8'h00;
    case (head_addr[7:5])
      3'd1, 3'd2, 3'd3, 3'd4, 3'd7: begin
        if (head_addr[4:0] <= 5'h15 && head_addr[2:0] < 3'd6) begin
          dec_valid = 1'b1;
          dec_group = head_addr[4:3];
          dec_sub   = head_addr[2:0];
          case (head_addr[7:5])
            3'd1:    dec_up[0] = 1'b1;
            3'd2:    dec_up[1] = 1'b1;
            3'd3:    dec_up[2] = 1'b1;
            3'd4:    dec_up[3] = 1'b1;
            default: dec_up[4] = 1'b1;
          endcase
        end
      end
      3'd5, 3'd6: begin
        if (head_addr[3:0] <= 4'd8 && !(head_addr[7:5] == 3'd6 && head_addr[4])) begin
          dec_valid = 1'b1;
          if (head_addr[7:5] == 3'd6)
            dec_up[7] = 1'b1;
          else if (head_addr[4])
            dec_up[6] = 1'b1;
          else
            dec_up[5] = 1'b1;
          // 3-bit wrap makes ch-6 correct for ch=8 (0-6 = 2 mod 8).
          if (head_addr[3:0] < 4'd3) begin
            dec_group = 2'd0;
            dec_sub   = head_addr[2:0];
          end else if (head_addr[3:0] < 4'd6) begin
            dec_group = 2'd1;
            dec_sub   = head_addr[2:0] - 3'd3;
          end else begin
            dec_group = 2'd2;
            dec_sub   = head_addr[2:0] - 3'd6;
          end
        end
      end
      default: ;
    endcase
  end

  // Launch FSM. The hold counter starts counting on the launch clk, so the
  // strobe spans exactly HOLD_CEN cen ticks. Invalid entries are popped in
  // IDLE and dropped without leaving IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      write     <= 1'b0;
      din       <= 8'h00;
      sel_group <= 2'd0;
      sel_sub   <= 3'd0;
      ups       <= 8'h00;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && dec_valid) begin
            din       <= head_data;
            sel_group <= dec_group;
            sel_sub   <= dec_sub;
            ups       <= dec_up;
            write     <= 1'b1;
            hold_cnt  <= '0;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          write <= 1'b0;
          if (cen)
            hold_cnt <= hold_cnt + 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          if (cen) begin
            if (hold_cnt >= CW'(HOLD_CEN - 1)) begin
              ups      <= 8'h00;
              hold_cnt <= '0;
              state    <= DONE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {up_fbcon, up_fnumhi, up_fnumlo, up_wav,
          up_sl_rr, up_ar_dr, up_ksl_tl, up_mult} = ups;

endmodule

// File: tb/tb_jtopl_wr_sched.sv
module tb_jtopl_wr_sched;

  localparam int HOLD_CEN = 21;
`ifdef JTOPL_WRQ_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       cpu_wr = 1'b0;
  logic       cpu_a0 = 1'b0;
  logic [7:0] cpu_din = 8'h00;
  logic       busy, write;
  logic [7:0] din;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav;
  logic       up_fnumlo, up_fnumhi, up_fbcon;
  logic       wave_mode, rhy_en, am_dep, vib_dep;
  logic [4:0] rhy_kon;
  logic [7:0] ups_vec;

  typedef struct {
    logic [7:0] d;
    logic [1:0] grp;
    logic [2:0] sub;
    logic [7:0] ups;
  } exp_t;

  exp_t sb[$];

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cen_mode = 0;
  bit   tracking = 1'b0;
  bit   have_prev = 1'b0;
  bit   din_bad = 1'b0;
  int   hold_ticks = 0;
  int   gap_cen = 0;
  logic [7:0] hold_din;

  jtopl_wr_sched #(.HOLD_CEN(HOLD_CEN)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .cpu_wr(cpu_wr), .cpu_a0(cpu_a0), .cpu_din(cpu_din),
    .busy(busy), .write(write), .din(din),
    .sel_group(sel_group), .sel_sub(sel_sub),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr),
    .up_sl_rr(up_sl_rr), .up_wav(up_wav),
    .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon),
    .wave_mode(wave_mode), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
    .am_dep(am_dep), .vib_dep(vib_dep)
  );

  assign ups_vec = {up_fbcon, up_fnumhi, up_fnumlo, up_wav,
                    up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};

  always #5 clk = ~clk;

  // cen for the next edge is driven shortly after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cen_mode == 0)
        cen = 1'b1;
      else
        cen = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: launches are compared against the queue, and every
  // strobe is timed in cen ticks from launch until it drops.
  always @(negedge clk) begin
    if (!rst) begin
      if (write) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_write", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("din", 32'(din), 32'(e.d));
          checkOutput("sel_group", 32'(sel_group), 32'(e.grp));
          checkOutput("sel_sub", 32'(sel_sub), 32'(e.sub));
          checkOutput("strobe", 32'(ups_vec), 32'(e.ups));
          if (have_prev)
            checkOutput("launch_gap", 32'(gap_cen >= HOLD_CEN), 32'd1);
          have_prev  = 1'b1;
          gap_cen    = 0;
          tracking   = 1'b1;
          hold_ticks = 0;
          hold_din   = din;
          din_bad    = 1'b0;
        end
      end
      if (tracking) begin
        if (ups_vec != 8'h00) begin
          if (cen)
            hold_ticks++;
          if (din !== hold_din)
            din_bad = 1'b1;
        end else begin
          checkOutput("hold_cen", 32'(hold_ticks), 32'(HOLD_CEN));
          checkOutput("din_stable", 32'(din_bad), 32'd0);
          tracking = 1'b0;
        end
      end
      if (cen)
        gap_cen++;
    end
  end

  task automatic cpuWrite(input logic a0, input logic [7:0] d);
    @(negedge clk);
    cpu_wr  = 1'b1;
    cpu_a0  = a0;
    cpu_din = d;
    @(negedge clk);
    cpu_wr  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input bit ok,
                               input logic [1:0] grp, input logic [2:0] sub,
                               input logic [7:0] ups);
    exp_t e;
    cpuWrite(1'b0, a);
    if (ok) begin
      e.d = d; e.grp = grp; e.sub = sub; e.ups = ups;
      sb.push_back(e);
    end
    cpuWrite(1'b1, d);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || tracking) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget)
      checkOutput("timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_strobes"}, 32'(ups_vec), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_write"}, 32'(write), 32'd0);
  endtask

  initial begin
    $display("[TB] start, queue capacity %0d", CAP);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkQuiet("reset");
    checkOutput("reset_din", 32'(din), 32'd0);
    checkOutput("reset_wave", 32'(wave_mode), 32'd0);
    checkOutput("reset_rhy", 32'({am_dep, vib_dep, rhy_en, rhy_kon}), 32'd0);
    repeat (50) @(negedge clk);
    checkQuiet("idle50");
    checkOutput("idle50_wave", 32'(wave_mode), 32'd0);
    checkOutput("idle50_kon", 32'(rhy_kon), 32'd0);

    // Basic operator write with continuous cen.
    applyStimulus(8'h23, 8'h21, 1, 2'd0, 3'd3, 8'h01);
    waitIdle(200);

    // Decode coverage under irregular cen.
    cen_mode = 1;
    applyStimulus(8'hA8, 8'h55, 1, 2'd2, 3'd2, 8'h20);
    waitIdle(400);
    applyStimulus(8'h26, 8'h77, 0, 2'd0, 3'd0, 8'h00);
    repeat (40) @(negedge clk);
    checkQuiet("invalid26");
    applyStimulus(8'hB4, 8'h31, 1, 2'd1, 3'd1, 8'h40);
    waitIdle(400);
    applyStimulus(8'hC8, 8'h0E, 1, 2'd2, 3'd2, 8'h80);
    waitIdle(400);
    applyStimulus(8'hF2, 8'h03, 1, 2'd2, 3'd2, 8'h10);
    waitIdle(400);
    applyStimulus(8'h55, 8'h3F, 1, 2'd2, 3'd5, 8'h02);
    waitIdle(400);
    applyStimulus(8'h76, 8'h44, 0, 2'd0, 3'd0, 8'h00);
    applyStimulus(8'hA9, 8'h45, 0, 2'd0, 3'd0, 8'h00);
    applyStimulus(8'h8B, 8'hF0, 1, 2'd1, 3'd3, 8'h08);
    waitIdle(400);
    applyStimulus(8'h61, 8'hA5, 1, 2'd0, 3'd1, 8'h04);
    waitIdle(400);

    // Global register 0x01.
    cpuWrite(1'b0, 8'h01);
    cpuWrite(1'b1, 8'h20);
    checkOutput("wave_mode", 32'(wave_mode), 32'd1);
    checkOutput("wave_busy", 32'(busy), 32'd0);

    // Global 0xBD written while a strobe is held.
    cen_mode = 0;
    applyStimulus(8'h40, 8'h3A, 1, 2'd0, 3'd0, 8'h02);
    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50)
        checkOutput("bd_launch_timeout", 32'd1, 32'd0);
    end
    repeat (4) @(negedge clk);
    cpuWrite(1'b0, 8'hBD);
    cpuWrite(1'b1, 8'h3F);
    checkOutput("bd_rhy_en", 32'(rhy_en), 32'd1);
    checkOutput("bd_rhy_kon", 32'(rhy_kon), 32'h1F);
    checkOutput("bd_depths", 32'({am_dep, vib_dep}), 32'd0);
    checkOutput("bd_busy", 32'(busy), 32'd0);
    checkOutput("bd_hold_undisturbed", 32'(ups_vec), 32'h02);
    waitIdle(200);
    cpuWrite(1'b0, 8'hBD);
    cpuWrite(1'b1, 8'hC0);
    checkOutput("bd_c0", 32'({am_dep, vib_dep, rhy_en, rhy_kon}), 32'hC0);

    // Back-to-back burst of six data writes to 0x20.
    cen_mode = 1;
    cpuWrite(1'b0, 8'h20);
    checkOutput("burst_pre_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (i < CAP + 1) begin
        exp_t e;
        e.d = 8'(8'h10 + i); e.grp = 2'd0; e.sub = 3'd0; e.ups = 8'h01;
        sb.push_back(e);
      end
      @(negedge clk);
      cpu_wr  = 1'b1;
      cpu_a0  = 1'b1;
      cpu_din = 8'(8'h10 + i);
    end
    @(negedge clk);
    cpu_wr = 1'b0;
    checkOutput("burst_busy", 32'(busy), 32'd1);
    waitIdle(3000);
    checkOutput("burst_drained_busy", 32'(busy), 32'd0);

    // Reset in the middle of a hold, with another entry queued behind it.
    cen_mode = 0;
    applyStimulus(8'h62, 8'h99, 1, 2'd0, 3'd2, 8'h04);
    cpuWrite(1'b0, 8'h63);
    cpuWrite(1'b1, 8'h11);
    begin
      int n = 0;
      while (!(tracking && hold_ticks >= 10) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100)
        checkOutput("rst_hold_timeout", 32'd1, 32'd0);
    end
    rst = 1'b1;
    tracking = 1'b0;
    @(negedge clk);
    checkQuiet("midhold_rst");
    rst = 1'b0;
    sb.delete();
    have_prev = 1'b0;
    repeat (80) @(negedge clk);
    checkQuiet("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
